// File: rtl/game_sequencer.sv
// Game-flow sequencer for the VGA game: WELCOME -> START countdown -> PLAY <-> PAUSE -> FINISH.
// Time is measured in vsync frames; a "second tick" is every FRAMES_PER_SEC frames.
module game_sequencer #(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int START_SECONDS   = 3,
  parameter int FINISH_HOLD_SEC = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       start_btn,
  input  logic       pause_sw,
  input  logic [7:0] time_left,
  output logic [2:0] game_state,
  output logic       timer_go,
  output logic       restart_timer,
  output logic [1:0] countdown,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [5:0] LP_FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [1:0] LP_START_CNT  = 2'(START_SECONDS);
  localparam logic [3:0] LP_HOLD       = 4'(FINISH_HOLD_SEC);

  state_t     r_state;
  logic [1:0] r_countdown;
  logic       r_frame_tick;
  logic [5:0] r_frame_cnt;
  logic [3:0] r_hold_cnt;
  logic       r_play_armed;
  logic       r_vsync_d;
  logic       r_btn_d;
  logic       r_live;

  logic w_vsync_rise;
  logic w_btn_rise;
  logic w_sec_tick;

  assign w_vsync_rise = vsync & ~r_vsync_d;
  assign w_btn_rise   = start_btn & ~r_btn_d;
  assign w_sec_tick   = r_frame_tick && (r_frame_cnt == LP_FRAME_LAST);

  // r_live stays low for the first edge after reset release so the edge
  // detectors load the live input levels before any event can fire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= WELCOME;
      r_countdown  <= 2'd0;
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= 6'd0;
      r_hold_cnt   <= 4'd0;
      r_play_armed <= 1'b0;
      r_vsync_d    <= 1'b0;
      r_btn_d      <= 1'b0;
      r_live       <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      r_btn_d   <= start_btn;
      r_live    <= 1'b1;
      if (!r_live) begin
        r_frame_tick <= 1'b0;
      end else begin
        r_frame_tick <= w_vsync_rise;
        if (r_frame_tick && (r_state != PAUSE)) begin
          r_frame_cnt <= w_sec_tick ? 6'd0 : r_frame_cnt + 6'd1;
        end
        if (r_frame_tick && (r_state == PLAY)) begin
          r_play_armed <= 1'b1;
        end
        case (r_state)
          WELCOME: begin
            if (w_btn_rise) begin
              r_state     <= START;
              r_countdown <= LP_START_CNT;
              r_frame_cnt <= 6'd0;
            end
          end
          START: begin
            if (w_sec_tick) begin
              if (r_countdown == 2'd1) begin
                r_state      <= PLAY;
                r_countdown  <= 2'd0;
                r_play_armed <= 1'b0;
              end else begin
                r_countdown <= r_countdown - 2'd1;
              end
            end
          end
          // Game over wins over pause when both happen on the same cycle.
          PLAY: begin
            if (r_play_armed && (time_left == 8'd0)) begin
              r_state     <= FINISH;
              r_frame_cnt <= 6'd0;
              r_hold_cnt  <= 4'd0;
            end else if (pause_sw) begin
              r_state <= PAUSE;
            end
          end
          PAUSE: begin
            if (!pause_sw) begin
              r_state <= PLAY;
            end
          end
          FINISH: begin
            if (r_hold_cnt == LP_HOLD) begin
              if (w_btn_rise) begin
                r_state <= WELCOME;
              end
            end else if (w_sec_tick) begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end
          end
          default: begin
            r_state     <= WELCOME;
            r_countdown <= 2'd0;
          end
        endcase
      end
    end
  end

  assign game_state    = r_state;
  assign countdown     = r_countdown;
  assign frame_tick    = r_frame_tick;
  assign timer_go      = (r_state == PLAY);
  assign restart_timer = (r_state == WELCOME) || (r_state == START);

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, is the number of vsync rising edges per game second (legal range 2..63).
REQ-002 Parameter START_SECONDS, default 3, is the length of the START countdown in seconds (legal range 1..3).
REQ-003 Parameter FINISH_HOLD_SEC, default 5, is the time in seconds for which FINISH ignores start_btn (legal range 1..15).
REQ-004 Port clock, input, 1 bit, is the single system clock (25 MHz pixel clock); all state is updated on its rising edge.
REQ-005 Port reset_n, input, 1 bit, is an asynchronous active-low reset.
REQ-006 Port vsync, input, 1 bit, is the VGA vsync level, synchronous to clock; a game frame is one rising edge of vsync.
REQ-007 Port start_btn, input, 1 bit, is the debounced start/chop button level, synchronous to clock.
REQ-008 Port pause_sw, input, 1 bit, is the pause switch level, synchronous to clock.
REQ-009 Port time_left, input, 8 bits, is the remaining game seconds reported by the game timer.
REQ-010 Port game_state, output, 3 bits, encodes the state: WELCOME=0, START=1, PLAY=2, PAUSE=3, FINISH=4.
REQ-011 Port timer_go, output, 1 bit, is the run enable for the game timer.
REQ-012 Port restart_timer, output, 1 bit, is the reload request for the game timer.
REQ-013 Port countdown, output, 2 bits, is the seconds remaining in START and 0 in every other state.
REQ-014 Port frame_tick, output, 1 bit, is a one-clock pulse on the cycle after each vsync rising edge is detected.

Function
REQ-015 The block SHALL detect vsync rising edges with one registered copy of vsync and assert frame_tick for exactly one cycle per rising edge.
REQ-016 The block SHALL detect start_btn rising edges with one registered copy of start_btn; a held level SHALL produce only one event.
REQ-017 A 6-bit frame counter SHALL increment on each frame_tick and wrap to 0 after reaching FRAMES_PER_SEC-1; the wrap is the "second tick".
REQ-018 On entering START or FINISH, the frame counter SHALL be cleared to 0.
REQ-019 In WELCOME, a start_btn rising edge SHALL move the state to START with countdown loaded to START_SECONDS.
REQ-020 In START, each second tick SHALL decrement countdown; the second tick that occurs with countdown==1 SHALL move the state to PLAY, and countdown SHALL then read 0.
REQ-021 In START, pause_sw and start_btn SHALL be ignored.
REQ-022 On entering PLAY from START, the play_armed flag SHALL be cleared; the first frame_tick in PLAY SHALL set it.
REQ-023 In PLAY with play_armed=1 and time_left==0, the state SHALL move to FINISH; this SHALL take priority over pause_sw.
REQ-024 In PLAY, when the FINISH condition is false and pause_sw=1, the state SHALL move to PAUSE.
REQ-025 In PAUSE, pause_sw=0 SHALL return the state to PLAY with play_armed unchanged, and the frame counter SHALL hold its value.
REQ-026 In FINISH, a 4-bit hold counter SHALL count second ticks up to FINISH_HOLD_SEC; start_btn rising edges SHALL be ignored until it reaches FINISH_HOLD_SEC.
REQ-027 In FINISH, once the hold counter has reached FINISH_HOLD_SEC, a start_btn rising edge SHALL move the state to WELCOME.
REQ-028 timer_go SHALL equal (state==PLAY), decoded from the registered state so there is no added latency.
REQ-029 restart_timer SHALL equal (state==WELCOME or state==START).
REQ-030 Every state transition SHALL take effect on the clock edge following the triggering event, i.e. a one-cycle latency.
REQ-031 An encoding of the state register outside 0..4 SHALL return the state to WELCOME on the next clock edge.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately, without a clock edge, set state=WELCOME, countdown=0, frame_tick=0, the frame and hold counters to 0, play_armed=0, and both edge-detect registers to 0.
REQ-033 While reset is asserted, the outputs SHALL read timer_go=0 and restart_timer=1.
REQ-034 Asserting reset mid-game in any state SHALL abandon that state with no further transition; release is synchronous to the next clock edge.

Verification
REQ-035 Scenario, start countdown (FRAMES_PER_SEC=4, START_SECONDS=3): a start_btn pulse in WELCOME -> state=1 and countdown=3; after 4 vsync edges countdown=2; after 12 vsync edges state=2, timer_go=1 and restart_timer=0.
REQ-036 Scenario, game end: in PLAY, drive time_left=0 before the first frame_tick -> the state stays 2; after one vsync edge with time_left=0 -> the state becomes 4 one cycle later.
REQ-037 Scenario, pause versus finish: in PLAY with play_armed=1, drive pause_sw=1 and time_left=0 on the same cycle -> state=4, not 3; with time_left=5 instead -> state=3 and timer_go=0; then pause_sw=0 -> state=2.
REQ-038 Scenario, finish hold (FRAMES_PER_SEC=4, FINISH_HOLD_SEC=2): a start_btn edge after 7 frames in FINISH is ignored; a start_btn edge after 8 or more frames -> state=0.
REQ-039 Scenario, reset mid-operation: assert reset_n=0 in START with countdown=2 and no clock edge -> state=0, countdown=0, restart_timer=1; holding start_btn high through reset release -> no transition.
REQ-040 Scenario, edge detect: hold start_btn high for 100 cycles in WELCOME -> exactly one transition to START, and the state does not advance further without second ticks.
